fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 40 ++++
 rtl/fetch_unit_pc_register.sv | 36 +++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit_pkg: opcodes, instruction field positions and fetch FSM states.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fetch_unit_pkg;

    localparam logic [7:0] c_op_nop = 8'h00;
    localparam logic [7:0] c_op_add = 8'h01;
    localparam logic [7:0] c_op_sub = 8'h02;
    localparam logic [7:0] c_op_ldi = 8'h03;
    localparam logic [7:0] c_op_ble = 8'h10;
    localparam logic [7:0] c_op_jmp = 8'h11;

    localparam int c_opcode_msb = 27;
    localparam int c_opcode_lsb = 20;
    localparam int c_dest_msb   = 19;
    localparam int c_dest_lsb   = 12;
    localparam int c_lit_msb    = 15;
    localparam int c_lit_lsb    = 0;

    // An all-zero word decodes as NOP with a zero literal.
    localparam logic [27:0] c_instr_nop = 28'd0;

    typedef enum logic [1:0] {
        c_st_run   = 2'd0,
        c_st_flush = 2'd1,
        c_st_delay = 2'd2
    } fetch_state_t;

    function automatic logic [7:0] instr_opcode(input logic [27:0] instr);
        return instr[c_opcode_msb:c_opcode_lsb];
    endfunction

    function automatic logic [15:0] instr_literal(input logic [27:0] instr);
        return instr[c_lit_msb:c_lit_lsb];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_pc_register.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit_pc_register: program counter with load / increment / hold.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_unit_pc_register
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_pc,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    // Load wins over increment; increment wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit: PC, ROM address and instruction register with branch flush.    |
// | Optional FETCH_NOP_DELAY_EN: NOP with nonzero literal stalls fetch.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 28,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'd0
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  oAddress,
    input  logic [INSTR_W-1:0] iInstruction,
    input  logic               iStall,
    input  logic               iBranchTaken,
    input  logic [7:0]         iBranchTarget,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [ADDR_W-1:0]  oPC,
    output logic               oValid
);

    fetch_state_t       r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [ADDR_W-1:0]  r_pc_out;
    logic               r_valid;
    logic [ADDR_W-1:0]  w_pc;
    logic [ADDR_W-1:0]  w_branch_pc;
    logic               w_in_delay;
    logic               w_pc_inc;

    assign w_branch_pc = {{(ADDR_W-8){1'b0}}, iBranchTarget};

`ifdef FETCH_NOP_DELAY_EN
    logic [15:0] r_delay_cnt;
    logic        w_start_delay;

    assign w_in_delay    = (r_state == c_st_delay);
    assign w_start_delay = (instr_opcode(iInstruction) == c_op_nop) &&
                           (instr_literal(iInstruction) != 16'd0);
`else
    assign w_in_delay = 1'b0;
`endif

    assign w_pc_inc = !iBranchTaken && !w_in_delay && !iStall;

    fetch_unit_pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (Clock),
        .rst       (Reset),
        .i_load    (iBranchTaken),
        .i_load_pc (w_branch_pc),
        .i_inc     (w_pc_inc),
        .o_pc      (w_pc)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= c_st_run;
            r_ir     <= INSTR_W'(c_instr_nop);
            r_pc_out <= '0;
            r_valid  <= 1'b0;
`ifdef FETCH_NOP_DELAY_EN
            r_delay_cnt <= 16'd0;
`endif
        end else if (iBranchTaken) begin
            // The word fetched this cycle belongs to the wrong path.
            r_state <= c_st_flush;
            r_ir    <= INSTR_W'(c_instr_nop);
            r_valid <= 1'b0;
`ifdef FETCH_NOP_DELAY_EN
            r_delay_cnt <= 16'd0;
`endif
`ifdef FETCH_NOP_DELAY_EN
        end else if (w_in_delay) begin
            r_valid <= 1'b0;
            if (r_delay_cnt == 16'd1) begin
                r_state     <= c_st_run;
                r_delay_cnt <= 16'd0;
            end else begin
                r_delay_cnt <= r_delay_cnt - 16'd1;
            end
`endif
        end else if (iStall) begin
            if (r_state == c_st_flush) begin
                r_valid <= 1'b0;
            end
        end else begin
            r_ir     <= iInstruction;
            r_pc_out <= w_pc;
            r_valid  <= 1'b1;
            r_state  <= c_st_run;
`ifdef FETCH_NOP_DELAY_EN
            if (w_start_delay) begin
                r_state     <= c_st_delay;
                r_delay_cnt <= instr_literal(iInstruction);
            end
`endif
        end
    end

    assign oAddress     = w_pc;
    assign oInstruction = r_ir;
    assign oPC          = r_pc_out;
    assign oValid       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_unit: randomized fetch traffic checked against a behavioural model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        iStall = 1'b0;
    logic        iBranchTaken = 1'b0;
    logic [7:0]  iBranchTarget = 8'd0;
    logic [15:0] oAddress, oPC, oAddress2, oPC2;
    logic [27:0] iInstruction, oInstruction, iInstruction2, oInstruction2;
    logic        oValid, oValid2;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    // ROM: mostly "address+100" words, with an occasional NOP carrying a small literal.
    function automatic logic [27:0] rom(input logic [15:0] a);
        if (a[3:0] == 4'hD && a[15:4] != 12'd0)
            return {8'h00, 4'h0, 14'h0, a[5:4]};
        return {8'h40, 4'h0, a + 16'd100};
    endfunction

    assign iInstruction  = rom(oAddress);
    assign iInstruction2 = rom(oAddress2);

    fetch_unit dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (oAddress),
        .iInstruction  (iInstruction),
        .iStall        (iStall),
        .iBranchTaken  (iBranchTaken),
        .iBranchTarget (iBranchTarget),
        .oInstruction  (oInstruction),
        .oPC           (oPC),
        .oValid        (oValid)
    );

    fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (oAddress2),
        .iInstruction  (iInstruction2),
        .iStall        (1'b0),
        .iBranchTaken  (1'b0),
        .iBranchTarget (8'd0),
        .oInstruction  (oInstruction2),
        .oPC           (oPC2),
        .oValid        (oValid2)
    );

    // Reference state: what the decode stage should see, plus remaining delay cycles.
    logic [15:0] m_pc, m_opc;
    logic [27:0] m_ir;
    logic        m_valid;
    int          m_delay;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit st, input bit br, input logic [7:0] tgt);
        logic [27:0] w;
        if (rst) begin
            m_pc = 16'd0; m_ir = 28'd0; m_opc = 16'd0; m_valid = 1'b0; m_delay = 0;
        end else if (br) begin
            m_pc = {8'd0, tgt}; m_ir = 28'd0; m_valid = 1'b0; m_delay = 0;
        end else if (m_delay > 0) begin
            m_valid = 1'b0;
            m_delay--;
        end else if (!st) begin
            w = rom(m_pc);
            m_ir = w; m_opc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd1;
`ifdef FETCH_NOP_DELAY_EN
            if (w[27:20] == 8'h00 && w[15:0] != 16'd0) m_delay = int'(w[15:0]);
`endif
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit br, input logic [7:0] tgt);
        Reset = rst; iStall = st; iBranchTaken = br; iBranchTarget = tgt;
        @(posedge Clock);
        model_edge(rst, st, br, tgt);
        #1;
        check("addr", 32'(oAddress), 32'(m_pc));
        check("ir", 32'(oInstruction), 32'(m_ir));
        check("opc", 32'(oPC), 32'(m_opc));
        check("valid", 32'(oValid), 32'(m_valid));
    endtask

    initial begin
        // Reset for three cycles.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'd0);
            check("wrap_reset_addr", 32'(oAddress2), 32'h0000FFFF);
        end
        check("reset_addr", 32'(oAddress), 32'd0);
        check("reset_valid", 32'(oValid), 32'd0);

        // First fetch: RESET_PC=FFFF instance wraps to 0.
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("first_ir", 32'(oInstruction), 32'({8'h40, 4'h0, 16'd100}));
        check("wrap_opc", 32'(oPC2), 32'h0000FFFF);
        check("wrap_addr", 32'(oAddress2), 32'd0);
        check("wrap_valid", 32'(oValid2), 32'd1);

        // Sequential fetch up to PC 5, then a 4-cycle stall.
        for (int i = 0; i < 20 && m_pc != 16'd5; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
        check("reach_pc5", 32'(m_pc), 32'd5);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'd0);
        check("stall_hold", 32'(oAddress), 32'd5);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("resume_opc", 32'(oPC), 32'd5);

        // Run to PC 9, branch to 6: one bubble then ROM[6].
        for (int i = 0; i < 20 && m_pc != 16'd9; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b1, 8'd6);
        check("br_addr", 32'(oAddress), 32'd6);
        check("br_bubble", 32'(oValid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("br_tgt_ir", 32'(oInstruction), 32'(rom(16'd6)));
        check("br_tgt_opc", 32'(oPC), 32'd6);
        check("br_tgt_valid", 32'(oValid), 32'd1);

        // Branch with stall on the same edge, then stall during the flush.
        step(1'b0, 1'b1, 1'b1, 8'h33);
        check("br_stall_addr", 32'(oAddress), 32'h33);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("flush_done_opc", 32'(oPC), 32'h33);

        // Mid-run reset followed by random traffic.
        step(1'b1, 1'b0, 1'b1, 8'h20);
        for (int i = 0; i < 400; i++)
            step(1'b0, ($urandom % 4) == 0, ($urandom % 8) == 0, 8'($urandom));
        // Long sequential stretch reaches NOP words at 0x1D, 0x2D, ...
        step(1'b0, 1'b0, 1'b1, 8'h10);
        for (int i = 0; i < 60; i++) step(1'b0, ($urandom % 6) == 0, 1'b0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
